// File: rtl/traffic_pkg.sv
// Shared lamp encodings, monitor state/fault-code types and per-road check helpers.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'b00,
    ST_MONITOR = 2'b01,
    ST_FAULT   = 2'b10
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_ILLEGAL  = 2'b01,
    FC_CONFLICT = 2'b10,
    FC_SEQUENCE = 2'b11
  } fault_code_t;

  // True when exactly one lamp of the road is lit.
  function automatic logic is_one_hot(input logic [2:0] lamp);
    logic ok;
    case (lamp)
      LAMP_RED, LAMP_YELLOW, LAMP_GREEN: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when prev->cur is a forbidden step, or yellow ended too early.
  function automatic logic bad_step(input logic [2:0] prev,
                                    input logic [2:0] cur,
                                    input logic [7:0] ycnt,
                                    input logic [7:0] min_yellow);
    logic bad;
    bad = 1'b0;
    if (prev == LAMP_GREEN && cur == LAMP_RED) begin
      bad = 1'b1;
    end else if (prev == LAMP_RED && cur == LAMP_YELLOW) begin
      bad = 1'b1;
    end else if (prev == LAMP_YELLOW && cur == LAMP_GREEN) begin
      bad = 1'b1;
    end else if (prev == LAMP_YELLOW && cur == LAMP_RED && ycnt < min_yellow) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Flash-pattern generator: phase toggles every FLASH_HALF cycles; restart
// reloads phase 1 with a zero count. phase_next is the value the phase
// register takes at the coming edge, so callers can register lamp drive in step.
module blink_gen #(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_next
);

  localparam logic [7:0] HALF_LAST = 8'(FLASH_HALF - 32'd1);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       phase_r;
  logic       phase_nxt_s;

  // Next count/phase: restart wins, otherwise count up and toggle at the half-period.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (restart) begin
      cnt_nxt_s   = 8'd0;
      phase_nxt_s = 1'b1;
    end else if (cnt_r >= HALF_LAST) begin
      cnt_nxt_s   = 8'd0;
      phase_nxt_s = ~phase_r;
    end else begin
      cnt_nxt_s   = cnt_r + 8'd1;
      phase_nxt_s = phase_r;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= 8'd0;
      phase_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  assign phase_next = phase_nxt_s;

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between an upstream signal controller and the lamps: passes
// legal aspects through with one cycle of latency and forces flashing red on
// any illegal encoding, conflict or bad sequence until acknowledged.
module light_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 8,
  parameter int unsigned FLASH_HALF     = 4,
  parameter int unsigned MIN_YELLOW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_light,
  input  logic [2:0] side_light,
  input  logic       clear,
  output logic [2:0] main_out,
  output logic [2:0] side_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [7:0] STARTUP_LAST = 8'(STARTUP_CYCLES - 32'd1);
  localparam logic [7:0] MIN_YEL      = 8'(MIN_YELLOW);

  mon_state_t  state_r, state_nxt_s;
  fault_code_t fault_code_r, code_nxt_s, viol_code_s;
  logic [7:0]  startup_cnt_r;
  logic [7:0]  ycnt_main_r, ycnt_side_r;
  logic [2:0]  prev_main_r, prev_side_r;
  logic [2:0]  main_out_r, side_out_r, main_nxt_s, side_nxt_s;
  logic        fault_r;
  logic        restart_s, phase_nxt_s;
  logic        illegal_s, conflict_s, sequence_s, inputs_ok_s;

  blink_gen #(.FLASH_HALF(FLASH_HALF)) u_blink (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart_s),
    .phase_next (phase_nxt_s)
  );

  // Raw violation terms from the current inputs and last cycle's inputs.
  always_comb begin
    illegal_s   = !is_one_hot(main_light) || !is_one_hot(side_light);
    conflict_s  = (main_light != LAMP_RED) && (side_light != LAMP_RED);
    sequence_s  = bad_step(prev_main_r, main_light, ycnt_main_r, MIN_YEL) ||
                  bad_step(prev_side_r, side_light, ycnt_side_r, MIN_YEL);
    inputs_ok_s = !illegal_s && !conflict_s;
  end

  // Prioritised violation code: illegal > conflict > sequence.
  always_comb begin
    viol_code_s = FC_NONE;
    if (illegal_s) begin
      viol_code_s = FC_ILLEGAL;
    end else if (conflict_s) begin
      viol_code_s = FC_CONFLICT;
    end else if (sequence_s) begin
      viol_code_s = FC_SEQUENCE;
    end else begin
      viol_code_s = FC_NONE;
    end
  end

  // Next state, flash restart and latched fault code.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = fault_code_r;
    restart_s   = 1'b0;
    case (state_r)
      ST_STARTUP: begin
        if (startup_cnt_r >= STARTUP_LAST) begin
          state_nxt_s = ST_MONITOR;
        end else begin
          state_nxt_s = ST_STARTUP;
        end
      end
      ST_MONITOR: begin
        if (viol_code_s != FC_NONE) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = viol_code_s;
          restart_s   = 1'b1;
        end else begin
          state_nxt_s = ST_MONITOR;
        end
      end
      ST_FAULT: begin
        if (clear && inputs_ok_s) begin
          state_nxt_s = ST_STARTUP;
          code_nxt_s  = FC_NONE;
          restart_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        // Corrupted state encoding: fall to the safe flashing state.
        state_nxt_s = ST_FAULT;
        code_nxt_s  = FC_SEQUENCE;
        restart_s   = 1'b1;
      end
    endcase
  end

  // Lamp drive: pass-through only when monitoring and clean, otherwise flash red.
  always_comb begin
    main_nxt_s = LAMP_RED;
    side_nxt_s = LAMP_RED;
    if (state_r == ST_MONITOR && viol_code_s == FC_NONE) begin
      main_nxt_s = main_light;
      side_nxt_s = side_light;
    end else if (phase_nxt_s) begin
      main_nxt_s = LAMP_RED;
      side_nxt_s = LAMP_RED;
    end else begin
      main_nxt_s = LAMP_DARK;
      side_nxt_s = LAMP_DARK;
    end
  end

  // State, fault outputs and registered lamp drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_STARTUP;
      fault_code_r <= FC_NONE;
      fault_r      <= 1'b0;
      main_out_r   <= LAMP_RED;
      side_out_r   <= LAMP_RED;
    end else begin
      state_r      <= state_nxt_s;
      fault_code_r <= code_nxt_s;
      fault_r      <= (state_nxt_s == ST_FAULT);
      main_out_r   <= main_nxt_s;
      side_out_r   <= side_nxt_s;
    end
  end

  // Startup dwell counter, runs only while in STARTUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      startup_cnt_r <= 8'd0;
    end else if (state_r == ST_STARTUP) begin
      startup_cnt_r <= startup_cnt_r + 8'd1;
    end else begin
      startup_cnt_r <= 8'd0;
    end
  end

  // Previous inputs and saturating yellow dwell counters, updated in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_main_r <= LAMP_RED;
      prev_side_r <= LAMP_RED;
      ycnt_main_r <= 8'd0;
      ycnt_side_r <= 8'd0;
    end else begin
      prev_main_r <= main_light;
      prev_side_r <= side_light;
      if (main_light != LAMP_YELLOW) begin
        ycnt_main_r <= 8'd0;
      end else if (ycnt_main_r != 8'hFF) begin
        ycnt_main_r <= ycnt_main_r + 8'd1;
      end else begin
        ycnt_main_r <= ycnt_main_r;
      end
      if (side_light != LAMP_YELLOW) begin
        ycnt_side_r <= 8'd0;
      end else if (ycnt_side_r != 8'hFF) begin
        ycnt_side_r <= ycnt_side_r + 8'd1;
      end else begin
        ycnt_side_r <= ycnt_side_r;
      end
    end
  end

  assign main_out   = main_out_r;
  assign side_out   = side_out_r;
  assign fault      = fault_r;
  assign fault_code = fault_code_r;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor at default parameters.
module tb_light_conflict_monitor;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] DRK = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [2:0] main_light = GRN;
  logic [2:0] side_light = RED;
  logic [2:0] main_out;
  logic [2:0] side_out;
  logic       fault;
  logic [1:0] fault_code;

  int n_vec = 0;
  int n_bad = 0;

  light_conflict_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .main_light (main_light),
    .side_light (side_light),
    .clear      (clear),
    .main_out   (main_out),
    .side_out   (side_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_lamps(input string tag, input logic [2:0] em, input logic [2:0] es);
    check({tag, ".main"}, {29'd0, main_out}, {29'd0, em});
    check({tag, ".side"}, {29'd0, side_out}, {29'd0, es});
  endtask

  task automatic chk_fault(input string tag, input logic ef, input logic [1:0] ec);
    check({tag, ".fault"}, {31'd0, fault}, {31'd0, ef});
    check({tag, ".code"}, {30'd0, fault_code}, {30'd0, ec});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    cyc(2);
    chk_lamps("reset", RED, RED);
    chk_fault("reset", 1'b0, 2'b00);

    // Startup flashing: 4 cycles red, 4 dark, then pass-through.
    rst = 1'b1;
    chk_lamps("start0", RED, RED);
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      chk_lamps($sformatf("start%0d", k), (k < 4) ? RED : DRK, (k < 4) ? RED : DRK);
    end
    cyc(2);
    chk_lamps("mon_entry", GRN, RED);
    chk_fault("mon_entry", 1'b0, 2'b00);

    // Legal main cycle with 3 yellow cycles, then side goes green.
    main_light = YEL;
    cyc(1);
    chk_lamps("yel1", YEL, RED);
    cyc(2);
    chk_lamps("yel3", YEL, RED);
    main_light = RED;
    cyc(1);
    chk_lamps("main_red", RED, RED);
    chk_fault("main_red", 1'b0, 2'b00);
    side_light = GRN;
    cyc(1);
    chk_lamps("side_grn", RED, GRN);
    chk_fault("side_grn", 1'b0, 2'b00);

    // Conflict: both green.
    main_light = GRN;
    cyc(1);
    chk_lamps("conflict", RED, RED);
    chk_fault("conflict", 1'b1, 2'b10);
    clear = 1'b1;
    cyc(1);
    chk_fault("clr_conflict", 1'b1, 2'b10);
    clear = 1'b0;
    cyc(2);
    chk_lamps("flash_hi", RED, RED);
    cyc(1);
    chk_lamps("flash_lo", DRK, DRK);

    // Acknowledge with legal inputs, then green appears after startup.
    main_light = RED;
    side_light = RED;
    clear = 1'b1;
    cyc(1);
    chk_fault("ack1", 1'b0, 2'b00);
    chk_lamps("ack1", RED, RED);
    clear = 1'b0;
    main_light = GRN;
    cyc(9);
    chk_lamps("ack1_track", GRN, RED);

    // Illegal encoding together with conflict: illegal wins.
    main_light = 3'b011;
    side_light = GRN;
    cyc(1);
    chk_lamps("illegal", RED, RED);
    chk_fault("illegal", 1'b1, 2'b01);
    clear = 1'b1;
    cyc(1);
    chk_fault("clr_illegal", 1'b1, 2'b01);

    // Acknowledge, then a one-cycle yellow is a timing violation.
    main_light = GRN;
    side_light = RED;
    cyc(1);
    chk_fault("ack2", 1'b0, 2'b00);
    clear = 1'b0;
    cyc(9);
    chk_lamps("ack2_track", GRN, RED);
    main_light = YEL;
    cyc(1);
    chk_lamps("short_yel", YEL, RED);
    main_light = RED;
    cyc(1);
    chk_lamps("short_yel_flt", RED, RED);
    chk_fault("short_yel_flt", 1'b1, 2'b11);
    clear = 1'b1;
    side_light = GRN;
    cyc(1);
    chk_fault("ack3", 1'b0, 2'b00);
    clear = 1'b0;
    cyc(9);
    chk_lamps("ack3_track", RED, GRN);
    chk_fault("ack3_track", 1'b0, 2'b00);

    // Exactly MIN_YELLOW cycles of yellow is legal.
    side_light = YEL;
    cyc(2);
    side_light = RED;
    cyc(1);
    chk_lamps("yel_min", RED, RED);
    chk_fault("yel_min", 1'b0, 2'b00);

    // Green straight to red, with clear asserted: still faults.
    side_light = GRN;
    cyc(1);
    chk_lamps("side_grn2", RED, GRN);
    side_light = RED;
    clear = 1'b1;
    cyc(1);
    chk_fault("grn_red", 1'b1, 2'b11);
    chk_lamps("grn_red", RED, RED);
    clear = 1'b0;
    cyc(4);
    chk_lamps("fault_dark", DRK, DRK);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b0;
    #1;
    chk_lamps("async_rst", RED, RED);
    chk_fault("async_rst", 1'b0, 2'b00);
    cyc(1);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
